// File: rtl/keypad_scan4x4_if.sv
// rtl/keypad_scan4x4_if.sv - keypad pins and accepted-key data bus
interface keypad_scan4x4_if;
  logic [3:0]  iCol;
  logic        iClr;
  logic [3:0]  oRow;
  logic [3:0]  oKey;
  logic        oValid;
  logic [31:0] oData;

  // Scanner side: reads columns and clear, drives rows and key data.
  modport master (
    input  iCol,
    input  iClr,
    output oRow,
    output oKey,
    output oValid,
    output oData
  );

  // Keypad / consumer side.
  modport slave (
    output iCol,
    output iClr,
    input  oRow,
    input  oKey,
    input  oValid,
    input  oData
  );
endinterface

// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 matrix keypad scanner, debouncer and hex key shifter
module keypad_scan4x4 #(
  parameter int DIV_W     = 15,
  parameter int DEB_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  keypad_scan4x4_if.master        bus
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS);

  logic [3:0]       sync1_q;
  logic [3:0]       col_s_q;
  logic [DIV_W-1:0] div_q;
  state_t           state_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       row_q;
  logic [3:0]       cnt_q;
  logic [3:0]       key_q;
  logic             valid_q;
  logic [31:0]      data_q;

  logic             tick;
  logic             col_any;
  logic [1:0]       col_idx_d;
  logic [1:0]       row_idx_d;
  logic [3:0]       cnt_d;
  logic             accept_d;
  logic [3:0]       accept_key_d;
  logic [31:0]      data_base_d;

  // Columns are asynchronous to clk; two flops before any logic sees them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      col_s_q <= 4'hF;
    end else begin
      sync1_q <= bus.iCol;
      col_s_q <= sync1_q;
    end
  end

  // Free-running scan divider; never stalled so tick spacing is constant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Tick, column priority decode (lowest column wins) and accept detection.
  always_comb begin
    tick      = &div_q;
    col_any   = (col_s_q != 4'hF);
    row_idx_d = row_idx_q + 2'd1;
    cnt_d     = cnt_q + 4'd1;
    col_idx_d = 2'd0;
    if (!col_s_q[3]) col_idx_d = 2'd3;
    if (!col_s_q[2]) col_idx_d = 2'd2;
    if (!col_s_q[1]) col_idx_d = 2'd1;
    if (!col_s_q[0]) col_idx_d = 2'd0;
    accept_d     = 1'b0;
    accept_key_d = {row_idx_q, col_idx_q};
    if (state_q == ST_SCAN) begin
      accept_key_d = {row_idx_q, col_idx_d};
      accept_d     = tick && col_any && (DEB_TICKS <= 1);
    end else if (state_q == ST_DEBOUNCE) begin
      accept_d     = tick && !col_s_q[col_idx_q] && (cnt_d == DEB_LAST);
    end
    data_base_d = bus.iClr ? 32'h0 : data_q;
  end

  // Scan/debounce/accept/release state machine with registered outputs.
  // Outputs are loaded on the edge entering ACCEPT so the valid pulse,
  // key and shifted data are all presented together during ACCEPT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      row_q     <= 4'b1110;
      cnt_q     <= 4'd0;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      data_q    <= 32'h0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          if (tick) begin
            if (!col_any) begin
              row_idx_q <= row_idx_d;
              row_q     <= ~(4'b0001 << row_idx_d);
            end else begin
              col_idx_q <= col_idx_d;
              cnt_q     <= 4'd1;
              state_q   <= (DEB_TICKS > 1) ? ST_DEBOUNCE : ST_ACCEPT;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tick) begin
            if (!col_s_q[col_idx_q]) begin
              cnt_q <= cnt_d;
              if (cnt_d == DEB_LAST) begin
                state_q <= ST_ACCEPT;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= ST_SCAN;
            end
          end
        end
        ST_ACCEPT: begin
          cnt_q   <= 4'd0;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (tick) begin
            if (!col_any) begin
              if (cnt_d == DEB_LAST) begin
                cnt_q   <= 4'd0;
                state_q <= ST_SCAN;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              cnt_q <= 4'd0;
            end
          end
        end
        default: begin
          state_q <= ST_SCAN;
          cnt_q   <= 4'd0;
        end
      endcase

      if (accept_d) begin
        valid_q <= 1'b1;
        key_q   <= accept_key_d;
        data_q  <= {data_base_d[27:0], accept_key_d};
      end else begin
        data_q  <= data_base_d;
      end
    end
  end

  assign bus.oRow   = row_q;
  assign bus.oKey   = key_q;
  assign bus.oValid = valid_q;
  assign bus.oData  = data_q;

endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb/tb_keypad_scan4x4.sv - scoreboard bench for keypad_scan4x4
module tb_keypad_scan4x4;

  logic clk;
  logic reset;

  keypad_scan4x4_if kp();

  keypad_scan4x4 #(.DIV_W(2), .DEB_TICKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kp)
  );

  // Keypad model: a pressed key pulls its columns low only while its row is driven.
  logic       key_active;
  logic [1:0] key_row;
  logic [3:0] key_cols;
  logic       ovr_en;
  logic [3:0] ovr_val;

  assign kp.iCol = ovr_en ? ovr_val :
                   ((key_active && !kp.oRow[key_row]) ? ~key_cols : 4'hF);

  int checks;
  int errors;
  int valid_cnt;
  logic [35:0] exp_q[$];
  logic [31:0] exp_data;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!reset && kp.oValid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid oKey=%h oData=%h expected no pulse", kp.oKey, kp.oData);
        end else begin
          e = exp_q.pop_front();
          check("valid_key", 32'(kp.oKey), 32'(e[35:32]));
          check("valid_data", kp.oData, e[31:0]);
        end
      end
    end
  endtask

  task automatic wait_valid(input int start);
    int n;
    n = 0;
    while (valid_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (valid_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=no pulse expected=pulse within 200 cycles");
    end
  endtask

  task automatic wait_row_enter(input logic [3:0] pat);
    int n;
    n = 0;
    while (kp.oRow == pat && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (kp.oRow != pat && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL row_timeout actual=%b expected=%b", kp.oRow, pat);
    end
  endtask

  task automatic press_key(input logic [1:0] r, input logic [3:0] cols, input logic [3:0] k,
                           input int hold_ticks, input bit chk_row);
    int start;
    int n;
    logic [3:0] held;
    held = ~(4'b0001 << r);
    exp_data = {exp_data[27:0], k};
    exp_q.push_back({k, exp_data});
    start = valid_cnt;
    key_row = r;
    key_cols = cols;
    key_active = 1'b1;
    wait_valid(start);
    repeat (hold_ticks * 4) @(negedge clk);
    if (chk_row) check("row_held_while_pressed", 32'(kp.oRow), 32'(held));
    key_active = 1'b0;
    if (chk_row) begin
      repeat (10) @(negedge clk);
      check("row_held_during_release", 32'(kp.oRow), 32'(held));
      n = 0;
      while (kp.oRow == held && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("scan_resumed", 32'(kp.oRow != held), 32'd1);
    end else begin
      repeat (20) @(negedge clk);
    end
    check("pulse_count", 32'(valid_cnt - start), 32'd1);
  endtask

  task automatic press_hex(input logic [3:0] k);
    press_key(k[3:2], 4'b0001 << k[1:0], k, 2, 1'b0);
  endtask

  initial begin
    logic [3:0] row_seq [5];
    logic [3:0] hex_seq [9];
    row_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    hex_seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};
    checks = 0;
    errors = 0;
    valid_cnt = 0;
    exp_data = 32'h0;
    clk = 1'b0;
    reset = 1'b1;
    key_active = 1'b0;
    key_row = 2'd0;
    key_cols = 4'h0;
    ovr_en = 1'b0;
    ovr_val = 4'hF;
    kp.iClr = 1'b0;
    fork
      monitor_loop();
    join_none

    #1;
    check("reset_oRow", 32'(kp.oRow), 32'h0000000E);
    check("reset_oKey", 32'(kp.oKey), 32'h0);
    check("reset_oValid", 32'(kp.oValid), 32'h0);
    check("reset_oData", kp.oData, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle scan: one row step per tick (every 4 clocks).
    for (int i = 0; i < 5; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("idle_row_step", 32'(kp.oRow), 32'(row_seq[i]));
    end
    check("idle_data", kp.oData, 32'h0);

    // Row 2 / col 1 -> key 9, row held through release.
    press_key(2'd2, 4'b0010, 4'h9, 3, 1'b1);
    check("key9_data", kp.oData, 32'h00000009);

    // Sequence shifts the oldest nibbles out.
    for (int i = 0; i < 9; i++) press_hex(hex_seq[i]);
    check("seq_data", kp.oData, 32'h2345678F);

    // Bounce on row 0: low for one tick, high for one tick.
    wait_row_enter(4'b1110);
    ovr_en = 1'b1;
    ovr_val = 4'b0111;
    repeat (4) @(posedge clk);
    @(negedge clk);
    ovr_val = 4'hF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bounce_row_not_advanced", 32'(kp.oRow), 32'h0000000E);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bounce_back_to_scan", 32'(kp.oRow), 32'h0000000D);
    ovr_en = 1'b0;
    press_key(2'd0, 4'b1000, 4'h3, 2, 1'b0);

    // Two keys on row 1: lowest column wins, long hold gives one pulse.
    press_key(2'd1, 4'b1010, 4'h5, 20, 1'b0);
    press_key(2'd1, 4'b0101, 4'h4, 2, 1'b0);
    check("twokey_data", kp.oData, 32'h5678F354);

    // Clear, then build 0x1234.
    kp.iClr = 1'b1;
    @(negedge clk);
    kp.iClr = 1'b0;
    check("clr_data", kp.oData, 32'h0);
    exp_data = 32'h0;
    for (int i = 0; i < 4; i++) press_hex(hex_seq[i]);
    check("pre_clr_data", kp.oData, 32'h00001234);

    // Key A accepted on the third tick after row 2 is entered; iClr on that edge.
    wait_row_enter(4'b1011);
    ovr_en = 1'b1;
    ovr_val = 4'b1011;
    exp_data = 32'h0000000A;
    exp_q.push_back({4'hA, exp_data});
    begin
      int start;
      start = valid_cnt;
      repeat (11) @(posedge clk);
      @(negedge clk);
      kp.iClr = 1'b1;
      @(negedge clk);
      kp.iClr = 1'b0;
      repeat (2) @(negedge clk);
      check("clr_accept_pulse", 32'(valid_cnt - start), 32'd1);
    end
    check("clr_accept_data", kp.oData, 32'h0000000A);
    ovr_val = 4'hF;
    repeat (24) @(negedge clk);
    ovr_en = 1'b0;

    // Reset while debouncing a row 1 key.
    wait_row_enter(4'b1101);
    ovr_en = 1'b1;
    ovr_val = 4'b1110;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_oRow", 32'(kp.oRow), 32'h0000000E);
    check("midreset_oKey", 32'(kp.oKey), 32'h0);
    check("midreset_oValid", 32'(kp.oValid), 32'h0);
    check("midreset_oData", kp.oData, 32'h0);
    ovr_val = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ovr_en = 1'b0;
    exp_data = 32'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("postreset_row_step", 32'(kp.oRow), 32'h0000000D);
    repeat (40) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
